// File: rtl/subneg_pkg.sv
// Shared types and instruction-field layout for the SUBNEG core.
package subneg_pkg;

    // Control FSM states; one instruction walks FETCH..EXEC in five cycles
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_RD_A   = 3'd3,
        S_RD_B   = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instruction word is {A, B, C}, each field one address wide
    localparam int NUM_FIELDS = 3;
    localparam int C_LSB      = 0;

    function automatic int instr_w(input int aw);
        return NUM_FIELDS * aw;
    endfunction

    function automatic int a_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int b_lsb(input int aw);
        return aw;
    endfunction

endpackage

// File: rtl/subneg_dmem.sv
// Data memory: one core read/write port plus a host read port and a host
// write port. Out-of-range addresses read as zero and ignore writes.
module subneg_dmem
    import subneg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_core_we,
    input  logic [AW-1:0]    i_core_addr,
    input  logic [WIDTH-1:0] i_core_wdata,
    output logic [WIDTH-1:0] o_core_rdata,
    input  logic             i_host_we,
    input  logic [AW-1:0]    i_host_addr,
    input  logic [WIDTH-1:0] i_host_wdata,
    output logic [WIDTH-1:0] o_host_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_core_in_range;
    logic             w_host_in_range;

    assign w_core_in_range = ({1'b0, i_core_addr} < (AW+1)'(DEPTH));
    assign w_host_in_range = ({1'b0, i_host_addr} < (AW+1)'(DEPTH));

    assign o_core_rdata = w_core_in_range ? r_mem[i_core_addr] : '0;
    assign o_host_rdata = w_host_in_range ? r_mem[i_host_addr] : '0;

    // Storage update; the core port wins, though the top never enables both at once
    always_ff @(posedge i_clk) begin
        if (i_core_we && w_core_in_range) begin
            r_mem[i_core_addr] <= i_core_wdata;
        end else if (i_host_we && w_host_in_range) begin
            r_mem[i_host_addr] <= i_host_wdata;
        end
    end

endmodule

// File: rtl/subneg_core.sv
// Multi-cycle SUBNEG core: mem[B] -= mem[A]; branch to C if the result is negative.
// External synchronous instruction memory, internal data memory, host debug port.
module subneg_core
    import subneg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16,
    parameter int CNTW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AW-1:0]     imem_addr,
    input  logic [3*AW-1:0]   imem_data,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [WIDTH-1:0]  host_wdata,
    output logic [WIDTH-1:0]  host_rdata,
    output logic              busy,
    output logic              halted,
    output logic [AW-1:0]     pc,
    output logic [CNTW-1:0]   instr_count
);

    localparam int INSTR_W = instr_w(AW);
    localparam int A_LSB   = a_lsb(AW);
    localparam int B_LSB   = b_lsb(AW);

    state_t               r_state;
    logic [AW-1:0]        r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [WIDTH-1:0]     r_op1;
    logic [WIDTH-1:0]     r_op2;
    logic [CNTW-1:0]      r_count;
    logic                 r_busy;
    logic                 r_halted;

    logic [AW-1:0]        w_a;
    logic [AW-1:0]        w_b;
    logic [AW-1:0]        w_c;
    logic [WIDTH-1:0]     w_result;
    logic                 w_neg;
    logic [AW-1:0]        w_core_addr;
    logic                 w_core_we;
    logic [WIDTH-1:0]     w_core_rdata;
    logic                 w_host_we;

    assign w_a = r_ir[A_LSB +: AW];
    assign w_b = r_ir[B_LSB +: AW];
    assign w_c = r_ir[C_LSB +: AW];

    // Wrapped subtraction; the sign bit alone decides the branch, zero falls through
    assign w_result = r_op2 - r_op1;
    assign w_neg    = w_result[WIDTH-1];

    // Core port reads A only in RD_A; B is addressed for both the read and the write-back
    assign w_core_addr = (r_state == S_RD_A) ? w_a : w_b;
    // Reset in the EXEC cycle suppresses the write-back
    assign w_core_we   = (r_state == S_EXEC) && !rst;
    // Host writes only land while the core is not executing
    assign w_host_we   = host_we && !r_busy;

    // The program counter doubles as the fetch address; the external memory returns data during DECODE
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign instr_count = r_count;

    subneg_dmem #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_dmem (
        .i_clk        (clk),
        .i_core_we    (w_core_we),
        .i_core_addr  (w_core_addr),
        .i_core_wdata (w_result),
        .o_core_rdata (w_core_rdata),
        .i_host_we    (w_host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_rdata (host_rdata)
    );

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state  <= S_FETCH;
                        r_pc     <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= S_RD_A;
                end
                S_RD_A: begin
                    r_op1   <= w_core_rdata;
                    r_state <= S_RD_B;
                end
                S_RD_B: begin
                    r_op2   <= w_core_rdata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_count <= r_count + CNTW'(1);
                    r_pc    <= w_neg ? w_c : (r_pc + AW'(1));
                    // A taken branch onto itself can never make progress: stop here
                    if (w_neg && (w_c == r_pc)) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subneg_core.sv
// Scoreboard bench for subneg_core: a program-level reference model queues the
// expected retirement sequence, and a negedge monitor checks retirements and probes.
module tb_subneg_core;

    localparam int WIDTH = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int CNTW  = 32;
    localparam int NADDR = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [AW-1:0]     imem_addr;
    logic [3*AW-1:0]   imem_data;
    logic              host_we;
    logic [AW-1:0]     host_addr;
    logic [WIDTH-1:0]  host_wdata;
    logic [WIDTH-1:0]  host_rdata;
    logic              busy;
    logic              halted;
    logic [AW-1:0]     pc;
    logic [CNTW-1:0]   instr_count;

    subneg_core #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction ROM: data appears one cycle after the address
    logic [3*AW-1:0] rom [NADDR];
    always @(posedge clk) imem_data <= rom[imem_addr];

    typedef struct {
        int pc;
        int cnt;
        bit halted;
    } ret_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } probe_t;

    ret_t   ret_q[$];
    probe_t probe_q[$];
    int     mdl [NADDR];
    int     n_tests = 0;
    int     n_fail  = 0;
    logic [CNTW-1:0] last_cnt;

    // Monitor: a retirement shows as instr_count stepping by one
    always @(negedge clk) begin
        ret_t        e;
        probe_t      p;
        logic [31:0] act;
        if (instr_count == last_cnt + 1) begin
            n_tests++;
            if (ret_q.size() == 0) begin
                n_fail++;
                $display("FAIL retire_unexpected: got count=%0d pc=%0d, required no retirement", instr_count, pc);
            end else begin
                e = ret_q.pop_front();
                if (pc !== AW'(e.pc) || instr_count !== CNTW'(e.cnt) || halted !== e.halted || busy !== !e.halted) begin
                    n_fail++;
                    $display("FAIL retire: got pc=%0d count=%0d halted=%0b busy=%0b, required pc=%0d count=%0d halted=%0b busy=%0b",
                             pc, instr_count, halted, busy, e.pc, e.cnt, e.halted, !e.halted);
                end
            end
        end
        last_cnt = instr_count;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.sel)
                0:       act = 32'(host_rdata);
                1:       act = 32'(pc);
                2:       act = 32'(busy);
                3:       act = 32'(halted);
                4:       act = 32'(instr_count);
                5:       act = 32'(imem_addr);
                default: act = 32'(ret_q.size());
            endcase
            n_tests++;
            if (act !== p.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, required 0x%0h", p.name, act, p.exp);
            end
        end
    end

    function automatic int rd(input int a);
        return (a < DEPTH) ? mdl[a] : 0;
    endfunction

    task automatic probe(input int sel, input int addr, input int exp, input string name);
        host_addr = AW'(addr);
        probe_q.push_back('{sel: sel, exp: 32'(exp), name: name});
        @(negedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input int data, input bit upd);
        host_addr  = AW'(addr);
        host_wdata = WIDTH'(data);
        host_we    = 1'b1;
        @(posedge clk); #1;
        host_we    = 1'b0;
        if (upd && addr < DEPTH) mdl[addr] = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < NADDR; i++) rom[i] = '0;
    endtask

    // Run the program on the model, queue its retirements, then let the DUT run it
    task automatic run_prog(input int max_ret, input bit disturb, input bit rst_after);
        int p;
        int c;
        bit h;
        int a;
        int b;
        int cc;
        int r;
        bit neg;
        p = 0; c = 0; h = 0;
        while (c < max_ret && !h) begin
            a  = int'(rom[p][11:8]);
            b  = int'(rom[p][7:4]);
            cc = int'(rom[p][3:0]);
            r  = (rd(b) - rd(a) + 256) % 256;
            if (b < DEPTH) mdl[b] = r;
            neg = (r >= 128);
            c++;
            h = neg && (cc == p);
            p = neg ? cc : (p + 1) % NADDR;
            ret_q.push_back('{pc: p, cnt: c, halted: h});
        end
        pulse_start();
        for (int cyc = 0; cyc < 5 * max_ret + 20 && ret_q.size() != 0; cyc++) begin
            if (disturb && cyc == 3) host_write(5, 'hAA, 1'b0);
            if (disturb && cyc == 7) pulse_start();
            @(posedge clk); #1;
        end
        probe(6, 0, 0, "pending_retirements");
        if (rst_after) do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clear_rom();
        for (int i = 0; i < NADDR; i++) mdl[i] = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;

        // Reset state, memory retained across reset
        host_write(4, 'h3C, 1'b1);
        do_reset();
        probe(2, 0, 0, "rst_busy");
        probe(3, 0, 0, "rst_halted");
        probe(1, 0, 0, "rst_pc");
        probe(4, 0, 0, "rst_count");
        probe(5, 0, 0, "rst_imem_addr");
        probe(0, 4, 'h3C, "rst_mem_kept");

        // Negative branch: 3 - 5 = 0xFE, taken to 7
        host_write(1, 5, 1'b1); host_write(2, 3, 1'b1);
        clear_rom(); rom[0] = {4'd1, 4'd2, 4'd7};
        run_prog(1, 1'b0, 1'b1);
        probe(0, 2, 'hFE, "neg_mem2");

        // Fall-through, then A==B gives zero
        host_write(1, 2, 1'b1); host_write(2, 9, 1'b1); host_write(3, 4, 1'b1);
        clear_rom(); rom[0] = {4'd1, 4'd2, 4'd9}; rom[1] = {4'd3, 4'd3, 4'd9};
        run_prog(2, 1'b0, 1'b1);
        probe(0, 2, 7, "fall_mem2");
        probe(0, 3, 0, "aeqb_mem3");

        // Self-loop halt, then restart from HALT
        host_write(0, 1, 1'b1); host_write(1, 0, 1'b1);
        clear_rom(); rom[0] = {4'd0, 4'd1, 4'd0};
        run_prog(5, 1'b0, 1'b0);
        probe(3, 0, 1, "halt_halted");
        probe(2, 0, 0, "halt_busy");
        probe(1, 0, 0, "halt_pc");
        probe(4, 0, 1, "halt_count");
        probe(0, 1, 'hFF, "halt_mem1");
        run_prog(5, 1'b0, 1'b0);
        probe(0, 1, 'hFE, "restart_mem1");
        do_reset();
        probe(3, 0, 0, "rst_clears_halted");

        // Host writes dropped while busy; a stray start mid-run is ignored
        host_write(5, 'h11, 1'b1);
        clear_rom();
        for (int i = 0; i < NADDR; i++) rom[i] = {4'(i), 4'(i), 4'd0};
        run_prog(4, 1'b1, 1'b1);
        probe(0, 5, 'h11, "busy_write_dropped");
        probe(0, 0, 0, "aeqb_mem0");
        host_write(5, 'hAA, 1'b1);
        probe(0, 5, 'hAA, "idle_write");

        // Out-of-range address reads zero, write dropped
        host_write(13, 'h55, 1'b1);
        probe(0, 13, 0, "oob_read");

        // Reset in the EXEC cycle suppresses the write
        host_write(1, 5, 1'b1); host_write(2, 3, 1'b1);
        clear_rom(); rom[0] = {4'd1, 4'd2, 4'd7};
        pulse_start();
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        probe(0, 2, 3, "exec_rst_mem2");
        probe(1, 0, 0, "exec_rst_pc");
        probe(2, 0, 0, "exec_rst_busy");
        probe(4, 0, 0, "exec_rst_count");
        rst = 1'b0;

        // Random programs against the model, then a full memory dump
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NADDR; i++) rom[i] = 12'($urandom);
            for (int i = 0; i < DEPTH; i++) host_write(i, int'($urandom_range(0, 255)), 1'b1);
            run_prog(25, 1'b0, 1'b1);
            for (int i = 0; i < NADDR; i++) probe(0, i, rd(i), "rand_dump");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/subneg_core.md
Name: subneg_core

Overview:
- Parametrised multi-cycle SUBNEG (subtract-and-branch-if-negative) processor core; the next generation of the fixed 8-bit SUBNEG datapath.
- Generalised data width, address width and data-memory depth. Adds an explicit control FSM, host preload/debug port, start/halt handshake, self-loop halt detection and a retired-instruction counter.
- Instruction memory is external and synchronous. Data memory is internal.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- AW, 4, address width for PC, instruction fields and data memory.
- DEPTH, 16, data memory words (<= 2**AW); addresses >= DEPTH read 0, writes dropped.
- CNTW, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins execution from PC=0 when idle or halted
- imem_addr  out  AW  instruction fetch address
- imem_data  in  3*AW  instruction {A[3AW-1:2AW], B[2AW-1:AW], C[AW-1:0]}; valid 1 cycle after imem_addr
- host_we  in  1  host write to data memory; honoured only when busy=0
- host_addr  in  AW  host read/write address
- host_wdata  in  WIDTH  host write data
- host_rdata  out  WIDTH  combinational mem[host_addr] (0 if out of range)
- busy  out  1  core executing
- halted  out  1  core stopped on self-loop branch
- pc  out  AW  current program counter
- instr_count  out  CNTW  instructions retired since last start

Behaviour:
- Semantics: mem[B] <= mem[B] - mem[A], modulo 2**WIDTH. neg = MSB of the wrapped result. If neg, PC <= C; else PC <= PC+1, wrapping at 2**AW. Zero is non-negative.
- Reset: state IDLE, pc=0, busy=0, halted=0, instr_count=0, imem_addr=0, IR/op1/op2 cleared. Data memory is NOT reset.
- FSM states: IDLE, FETCH, DECODE, RD_A, RD_B, EXEC, HALT.
- IDLE: start -> FETCH, pc<=0, instr_count<=0.
- HALT: start behaves as in IDLE and clears halted.
- FETCH: imem_addr=pc -> DECODE.
- DECODE: IR <= imem_data -> RD_A.
- RD_A: op1 <= mem[A] -> RD_B.
- RD_B: op2 <= mem[B] -> EXEC.
- EXEC: write mem[B], update pc, instr_count += 1 (wraps).
  - Go to HALT if neg and C == pc (self-loop); this instruction counts as retired. Otherwise -> FETCH.
- Latency: exactly 5 cycles per instruction from FETCH entry to next FETCH entry.
- busy=1 in FETCH..EXEC; halted=1 only in HALT.
- start is ignored while busy.
- A==B gives result 0: write 0, non-negative.
- host_we while busy=1 is dropped silently.
- host_rdata is combinational and valid in any state.
- rst asserted mid-instruction (including EXEC) has priority: no memory write that cycle, state -> IDLE.

Decomposition:
- Package subneg_pkg: state_t enum; instruction field slice helpers/localparams for A/B/C offsets; localparam INSTR_W = 3*AW.
- One sub-module, subneg_dmem: DEPTH x WIDTH array with one core read/write port, host read port and host write port with range guard. The core FSM arbitrates the write port via busy.

Test Plan:
- Reset: assert rst 2 cycles -> busy=0, halted=0, pc=0, instr_count=0, imem_addr=0; preloaded mem contents retained.
- Negative branch (WIDTH=8, AW=4): host mem[1]=5, mem[2]=3; instr@0 = {A=1,B=2,C=7}; start -> 5 cycles later mem[2]=0xFE, pc=7, instr_count=1.
- Fall-through: mem[1]=2, mem[2]=9, instr@0 = {1,2,9} -> mem[2]=7, pc=1. Also instr {3,3,9} with mem[3]=4 -> mem[3]=0, pc+1.
- Halt: mem[0]=1, mem[1]=0; instr@0 = {0,1,0} -> mem[1]=0xFF, halted=1, busy=0, pc=0, instr_count=1. A second start restarts from pc=0.
- Host protection: host_we mem[5]=0xAA while busy -> mem[5] unchanged. The same write while idle -> host_rdata=0xAA.
- Reset mid-EXEC: assert rst in the EXEC cycle of the negative-branch program -> mem[2] still 3, state IDLE, pc=0.
